instr_fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the TDM arbiter's instruction port.
- Generates sequential fetch addresses and runs the reqI/memIReady handshake with the arbiter.
- Buffers returned instruction words, with their PCs, in a small prefetch FIFO.
- Presents instructions to decode through a valid/ready handshake, and supports PC redirect/flush from branch resolution.

---
 rtl/instr_fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-fetch front end placed directly upstream of the TDM arbiter's
// instruction port. It walks the PC sequentially, issues one fetch at a time
// over the reqI/memIReady handshake, buffers returned words with their PCs
// in a small prefetch FIFO, and hands them to decode over a valid/ready
// handshake. A redirect from branch resolution flushes the FIFO and restarts
// fetch at a new PC; an in-flight request is never withdrawn, its data is
// simply dropped when it arrives.
//
// Ports:
//   clk         in   system clock, rising-edge
//   reset       in   asynchronous active-low reset
//   memIAddr    out  fetch address, stable while reqI is high
//   reqI        out  fetch request to the arbiter
//   memIReady   in   one-cycle completion strobe, memIData valid with it
//   memIData    in   returned instruction word
//   redirect    in   flush and restart fetch at redirectPc
//   redirectPc  in   new fetch PC
//   instrValid  out  FIFO head valid
//   instrReady  in   decode accepts the head (pop on valid & ready)
//   instr       out  head instruction word
//   instrPc     out  head PC
//   fifoCount   out  current FIFO occupancy
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                 IADDR_W    = 32,
    parameter int                 IDATA_W    = 32,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [IADDR_W-1:0] RESET_PC   = '0,
    parameter int                 PC_STEP    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [IADDR_W-1:0]            memIAddr,
    output logic                          reqI,
    input  logic                          memIReady,
    input  logic [IDATA_W-1:0]            memIData,
    input  logic                          redirect,
    input  logic [IADDR_W-1:0]            redirectPc,
    output logic                          instrValid,
    input  logic                          instrReady,
    output logic [IDATA_W-1:0]            instr,
    output logic [IADDR_W-1:0]            instrPc,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [IADDR_W-1:0] STEP_C  = IADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,   // no request outstanding
        S_REQ,    // request outstanding, its data will be kept
        S_DRAIN   // request outstanding, its data will be discarded
    } state_e;

    state_e              state_q;
    logic [IADDR_W-1:0]  pc_q;
    logic [IADDR_W-1:0]  addr_q;
    logic                req_q;

    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    logic [IADDR_W-1:0]  pc_mem_q   [FIFO_DEPTH];
    logic [IDATA_W-1:0]  data_mem_q [FIFO_DEPTH];

    logic                pop;
    logic                push;
    logic                flush;
    logic [CNT_W-1:0]    occ_after_pop;

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pop           = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        count_d       = count_q;
        occ_after_pop = count_q;

        pop   = (count_q != '0) && instrReady;
        // A redirect always empties the FIFO; nothing in it belongs to the
        // new instruction stream.
        flush = redirect;
        // Only a response to a live request is kept; DRAIN data is dropped.
        push  = (state_q == S_REQ) && memIReady && !redirect;

        // Occupancy seen by the issue decision, crediting a same-cycle pop.
        occ_after_pop = count_q - CNT_W'(pop);

        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                // Pointers wrap naturally because FIFO_DEPTH is a power of two.
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only read when
    // count_q says they were written, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            data_mem_q[wr_ptr_q] <= memIData;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch FSM with registered request outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // memIReady is ignored here: nothing is outstanding.
                    if (redirect) begin
                        pc_q <= redirectPc;
                    end else if (occ_after_pop < DEPTH_C) begin
                        state_q <= S_REQ;
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (redirect) begin
                        pc_q <= redirectPc;
                        if (memIReady) begin
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            // The arbiter may already be servicing this
                            // request, so keep it asserted and drop its data.
                            state_q <= S_DRAIN;
                        end
                    end else if (memIReady) begin
                        pc_q    <= pc_q + STEP_C;
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (redirect) begin
                        pc_q <= redirectPc;
                    end
                    if (memIReady) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign memIAddr   = addr_q;
    assign reqI       = req_q;
    assign instrValid = (count_q != '0);
    assign instr      = data_mem_q[rd_ptr_q];
    assign instrPc    = pc_mem_q[rd_ptr_q];
    assign fifoCount  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main DUT (RESET_PC = 0)
    logic [AW-1:0] memIAddr;
    logic          reqI;
    logic          memIReady;
    logic [DW-1:0] memIData;
    logic          redirect;
    logic [AW-1:0] redirectPc;
    logic          instrValid;
    logic          instrReady;
    logic [DW-1:0] instr;
    logic [AW-1:0] instrPc;
    logic [CW-1:0] fifoCount;

    // Second DUT for PC wrap-around (RESET_PC = 0xFFFFFFFC)
    logic [AW-1:0] w_memIAddr;
    logic          w_reqI;
    logic          w_memIReady;
    logic [DW-1:0] w_memIData;
    logic          w_redirect;
    logic [AW-1:0] w_redirectPc;
    logic          w_instrValid;
    logic          w_instrReady;
    logic [DW-1:0] w_instr;
    logic [AW-1:0] w_instrPc;
    logic [CW-1:0] w_fifoCount;

    instr_fetch_unit #(
        .IADDR_W(AW), .IDATA_W(DW), .FIFO_DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset(reset),
        .memIAddr(memIAddr), .reqI(reqI),
        .memIReady(memIReady), .memIData(memIData),
        .redirect(redirect), .redirectPc(redirectPc),
        .instrValid(instrValid), .instrReady(instrReady),
        .instr(instr), .instrPc(instrPc), .fifoCount(fifoCount)
    );

    instr_fetch_unit #(
        .IADDR_W(AW), .IDATA_W(DW), .FIFO_DEPTH(DEPTH),
        .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)
    ) dut_wrap (
        .clk(clk), .reset(reset),
        .memIAddr(w_memIAddr), .reqI(w_reqI),
        .memIReady(w_memIReady), .memIData(w_memIData),
        .redirect(w_redirect), .redirectPc(w_redirectPc),
        .instrValid(w_instrValid), .instrReady(w_instrReady),
        .instr(w_instr), .instrPc(w_instrPc), .fifoCount(w_fifoCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memIReady    = 1'b0;
        memIData     = '0;
        redirect     = 1'b0;
        redirectPc   = '0;
        instrReady   = 1'b0;
        w_memIReady  = 1'b0;
        w_memIData   = '0;
        w_redirect   = 1'b0;
        w_redirectPc = '0;
        w_instrReady = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Wait (bounded) for the main DUT to raise reqI.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (reqI) ok = 1'b1;
            else      tick();
        end
    endtask

    // Act as the arbiter: complete the current request with data d.
    task automatic respond(input logic [DW-1:0] d);
        memIReady = 1'b1;
        memIData  = d;
        tick();
        memIReady = 1'b0;
        memIData  = '0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++; if (reqI !== 1'b0) begin n_fail++; $display("FAIL reset_reqI got %b exp 0", reqI); end
        n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instrValid); end
        n_checks++; if (fifoCount !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifoCount); end
        n_checks++; if (memIAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", memIAddr); end
        reset = 1'b1;
        tick();
        n_checks++; if (reqI !== 1'b1) begin n_fail++; $display("FAIL release_reqI got %b exp 1", reqI); end
        n_checks++; if (memIAddr !== 32'h0) begin n_fail++; $display("FAIL release_addr got %h exp 0", memIAddr); end
        // Assert reset mid-cycle: reqI must drop without a clock edge.
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (reqI !== 1'b0) begin n_fail++; $display("FAIL async_reset_reqI got %b exp 0", reqI); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        tick();
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h0) begin n_fail++; $display("FAIL single_req got req=%b addr=%h exp 1/0", reqI, memIAddr); end
        n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL single_nobypass got %b exp 0", instrValid); end
        respond(32'h0000_00A5);
        n_checks++; if (instrValid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", instrValid); end
        n_checks++; if (instr !== 32'hA5) begin n_fail++; $display("FAIL single_instr got %h exp a5", instr); end
        n_checks++; if (instrPc !== 32'h0) begin n_fail++; $display("FAIL single_pc got %h exp 0", instrPc); end
        n_checks++; if (reqI !== 1'b0) begin n_fail++; $display("FAIL single_reqlow got %b exp 0", reqI); end
        tick();
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h4) begin n_fail++; $display("FAIL single_next got req=%b addr=%h exp 1/4", reqI, memIAddr); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        instrReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_req(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout req %0d got none exp reqI", i); end
            n_checks++; if (memIAddr !== AW'(4 * i)) begin n_fail++; $display("FAIL bp_addr got %h exp %h", memIAddr, 4 * i); end
            respond(32'h1000 + DW'(i));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (reqI !== 1'b0 || fifoCount !== 3'd4) begin n_fail++; $display("FAIL bp_full got req=%b cnt=%0d exp 0/4", reqI, fifoCount); end
        end
        n_checks++; if (instr !== 32'h1000 || instrPc !== 32'h0) begin n_fail++; $display("FAIL bp_head got %h@%h exp 1000@0", instr, instrPc); end
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        n_checks++; if (fifoCount !== 3'd3) begin n_fail++; $display("FAIL bp_pop_count got %0d exp 3", fifoCount); end
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h10) begin n_fail++; $display("FAIL bp_refill got req=%b addr=%h exp 1/10", reqI, memIAddr); end
        n_checks++; if (instrPc !== 32'h4) begin n_fail++; $display("FAIL bp_newhead got %h exp 4", instrPc); end
    endtask

    task automatic test_redirect_req();
        bit ok;
        do_reset();
        instrReady = 1'b0;
        wait_req(ok);
        respond(32'h11);
        wait_req(ok);
        n_checks++; if (!ok || memIAddr !== 32'h4) begin n_fail++; $display("FAIL rd_pre got ok=%b addr=%h exp 1/4", ok, memIAddr); end
        redirect   = 1'b1;
        redirectPc = 32'h100;
        tick();
        redirect = 1'b0;
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h4) begin n_fail++; $display("FAIL rd_held got req=%b addr=%h exp 1/4", reqI, memIAddr); end
        n_checks++; if (fifoCount !== 3'd0 || instrValid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got cnt=%0d v=%b exp 0/0", fifoCount, instrValid); end
        repeat (3) tick();
        n_checks++; if (reqI !== 1'b1) begin n_fail++; $display("FAIL rd_still got %b exp 1", reqI); end
        respond(32'hDEAD);
        n_checks++; if (reqI !== 1'b0 || fifoCount !== 3'd0) begin n_fail++; $display("FAIL rd_drop got req=%b cnt=%0d exp 0/0", reqI, fifoCount); end
        tick();
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h100) begin n_fail++; $display("FAIL rd_next got req=%b addr=%h exp 1/100", reqI, memIAddr); end
        // Second redirect while already draining: newest PC wins.
        redirect   = 1'b1;
        redirectPc = 32'h300;
        tick();
        redirectPc = 32'h380;
        tick();
        redirect = 1'b0;
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h100) begin n_fail++; $display("FAIL rd_drain got req=%b addr=%h exp 1/100", reqI, memIAddr); end
        respond(32'hBEEF);
        tick();
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h380 || fifoCount !== 3'd0) begin n_fail++; $display("FAIL rd_drain_next got req=%b addr=%h cnt=%0d exp 1/380/0", reqI, memIAddr, fifoCount); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        instrReady = 1'b0;
        wait_req(ok);
        respond(32'h1);
        wait_req(ok);
        respond(32'h2);
        wait_req(ok);
        n_checks++; if (!ok || fifoCount !== 3'd2 || memIAddr !== 32'h8) begin n_fail++; $display("FAIL sim_pre got ok=%b cnt=%0d addr=%h exp 1/2/8", ok, fifoCount, memIAddr); end
        redirect   = 1'b1;
        redirectPc = 32'h200;
        memIReady  = 1'b1;
        memIData   = 32'hBAD;
        instrReady = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (fifoCount !== 3'd0 || instrValid !== 1'b0 || reqI !== 1'b0) begin n_fail++; $display("FAIL sim_flush got cnt=%0d v=%b req=%b exp 0/0/0", fifoCount, instrValid, reqI); end
        tick();
        n_checks++; if (reqI !== 1'b1 || memIAddr !== 32'h200) begin n_fail++; $display("FAIL sim_next got req=%b addr=%h exp 1/200", reqI, memIAddr); end
    endtask

    task automatic test_fifo_wrap();
        bit ok;
        do_reset();
        instrReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_req(ok);
            n_checks++; if (!ok || memIAddr !== AW'(4 * i)) begin n_fail++; $display("FAIL fw_addr got ok=%b addr=%h exp %h", ok, memIAddr, 4 * i); end
            respond(32'hC0DE_0000 + DW'(i));
            n_checks++; if (instrValid !== 1'b1 || instr !== 32'hC0DE_0000 + DW'(i) || instrPc !== AW'(4 * i)) begin
                n_fail++; $display("FAIL fw_head got v=%b %h@%h exp %h@%h", instrValid, instr, instrPc, 32'hC0DE_0000 + i, 4 * i);
            end
        end
        instrReady = 1'b0;
    endtask

    task automatic test_pc_wrap();
        bit ok;
        do_reset();
        w_instrReady = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin if (w_reqI) ok = 1'b1; else tick(); end
        n_checks++; if (!ok || w_memIAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL pcw_first got ok=%b addr=%h exp fffffffc", ok, w_memIAddr); end
        w_memIReady = 1'b1;
        w_memIData  = 32'h1234_5678;
        tick();
        w_memIReady = 1'b0;
        n_checks++; if (w_instrPc !== 32'hFFFF_FFFC || w_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL pcw_head got %h@%h exp 12345678@fffffffc", w_instr, w_instrPc); end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin if (w_reqI) ok = 1'b1; else tick(); end
        n_checks++; if (!ok || w_memIAddr !== 32'h0) begin n_fail++; $display("FAIL pcw_second got ok=%b addr=%h exp 0", ok, w_memIAddr); end
        w_instrReady = 1'b0;
    endtask

    // Random traffic against a transaction-level model: expected fetch PC,
    // a queue of {pc, word} the decoder should see, and one in-flight request.
    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } entry_t;

    task automatic test_random();
        entry_t        q[$];
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] out_addr;
        logic [CW-1:0] exp_cnt;
        bit            outstanding;
        bit            stale;
        bit            pop;
        int            lat;
        int            n_req;
        do_reset();
        exp_pc      = '0;
        out_addr    = '0;
        outstanding = 1'b0;
        stale       = 1'b0;
        lat         = 0;
        n_req       = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_cnt = CW'(q.size());
            n_checks++; if (fifoCount !== exp_cnt) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, fifoCount, exp_cnt); end
            n_checks++; if (instrValid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, instrValid, q.size() != 0); end
            if (q.size() != 0) begin
                n_checks++; if (instr !== q[0].word || instrPc !== q[0].pc) begin n_fail++; $display("FAIL rnd_head cyc %0d got %h@%h exp %h@%h", cyc, instr, instrPc, q[0].word, q[0].pc); end
            end
            if (reqI && !outstanding) begin
                n_req++;
                n_checks++; if (memIAddr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, memIAddr, exp_pc); end
                n_checks++; if (q.size() >= DEPTH) begin n_fail++; $display("FAIL rnd_issue_full cyc %0d got occupancy %0d exp <%0d", cyc, q.size(), DEPTH); end
                outstanding = 1'b1;
                stale       = 1'b0;
                out_addr    = memIAddr;
                lat         = $urandom_range(0, 3);
            end else if (outstanding) begin
                n_checks++; if (reqI !== 1'b1 || memIAddr !== out_addr) begin n_fail++; $display("FAIL rnd_hold cyc %0d got req=%b addr=%h exp 1/%h", cyc, reqI, memIAddr, out_addr); end
            end

            instrReady = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 15) == 0);
            redirectPc = AW'($urandom_range(0, 1023)) << 2;
            memIData   = $urandom;
            memIReady  = outstanding && (lat == 0);
            if (outstanding && lat > 0) lat--;

            pop = (q.size() != 0) && instrReady;
            if (redirect) begin
                q.delete();
                exp_pc = redirectPc;
                if (outstanding) stale = 1'b1;
            end else begin
                if (pop) void'(q.pop_front());
                if (memIReady && !stale) begin
                    q.push_back('{pc: out_addr, word: memIData});
                    exp_pc = out_addr + 32'd4;
                end
            end
            if (memIReady) outstanding = 1'b0;
            tick();
        end
        idle_inputs();
        n_checks++; if (n_req < 100) begin n_fail++; $display("FAIL rnd_progress got %0d requests exp >=100", n_req); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_redirect_req();
        test_simultaneous();
        test_fifo_wrap();
        test_pc_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
